// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational ALU
// between two requesters.
//
// state | meaning
// IDLE  | arbitrate; the granted requester sees ready and is captured
// ISSUE | captured operands settle on the ALU for one full cycle
// RESP  | registered result offered on the response channel
module alu_arbiter #(
  parameter int W   = 4,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_x,
  input  logic [W-1:0]   alu_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_x,
  output logic [W-1:0]   rsp_y,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t         state;
  logic           last_grant;
  logic           grant;
  logic           any_valid;
  logic [OPW-1:0] op_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           id_r;

  // The ALU only ever sees captured operands, never live requester inputs.
  assign alu_op = op_r;
  assign alu_a  = a_r;
  assign alu_b  = b_r;
  assign rsp_id = id_r;

  // Grant selection: a lone requester wins, a tie goes to whoever lost last time.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    req0_ready = (state == IDLE) && any_valid && !grant;
    req1_ready = (state == IDLE) && any_valid && grant;
  end

  // Sequencer: capture request, let the ALU settle, register and hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      id_r       <= 1'b0;
      rsp_x      <= '0;
      rsp_y      <= '0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_r       <= grant ? req1_op : req0_op;
            a_r        <= grant ? req1_a  : req0_a;
            b_r        <= grant ? req1_b  : req0_b;
            id_r       <= grant;
            last_grant <= grant;
            state      <= ISSUE;
            busy       <= 1'b1;
          end
        end
        ISSUE: begin
          rsp_x     <= alu_x;
          rsp_y     <= alu_y;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;
  localparam int W   = 4;
  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready;
  logic [OPW-1:0] req0_op;
  logic [W-1:0]   req0_a, req0_b;
  logic           req1_valid, req1_ready;
  logic [OPW-1:0] req1_op;
  logic [W-1:0]   req1_a, req1_b;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_x, alu_y;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]   rsp_x, rsp_y;
  logic           busy;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_x(alu_x), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y),
    .busy(busy)
  );

  // Behavioural ALU: 1010 add (carry in y), 1100 multiply (upper bits in y), else x=a^b, y=a&b.
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      4'b1010: alu_model = {4'b0, a} + {4'b0, b};
      4'b1100: alu_model = {4'b0, a} * {4'b0, b};
      default: alu_model = {a & b, a ^ b};
    endcase
  endfunction

  always_comb {alu_y, alu_x} = alu_model(alu_op, alu_a, alu_b);

  typedef struct {
    logic       id;
    logic [3:0] op, a, b, x, y;
  } vec_t;

  typedef struct {
    logic       id;
    logic [3:0] x, y;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_e;
  vec_t tbl[8];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every response handshake must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 8'(rsp_valid), 8'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_id", 8'(rsp_id), 8'(mon_e.id));
        check("rsp_x", 8'(rsp_x), 8'(mon_e.x));
        check("rsp_y", 8'(rsp_y), 8'(mon_e.y));
      end
    end
  end

  task automatic drive(input logic id, input logic v, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // One isolated operation with latency and operand-isolation checks; enters and leaves #1 after posedge.
  task automatic do_op(input vec_t v);
    int   n;
    logic rdy;
    drive(v.id, 1'b1, v.op, v.a, v.b);
    @(negedge clk);
    n   = 0;
    rdy = v.id ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = v.id ? req1_ready : req0_ready;
    end
    check("req_ready", 8'(rdy), 8'd1);
    check("other_ready", 8'(v.id ? req0_ready : req1_ready), 8'd0);
    sb_q.push_back('{v.id, v.x, v.y});
    @(posedge clk); #1;
    drive(v.id, 1'b0, v.op, ~v.a, ~v.b);
    @(negedge clk);
    check("issue_busy", 8'(busy), 8'd1);
    check("issue_rsp_valid", 8'(rsp_valid), 8'd0);
    check("alu_op_hold", 8'(alu_op), 8'(v.op));
    check("alu_a_hold", 8'(alu_a), 8'(v.a));
    check("alu_b_hold", 8'(alu_b), 8'(v.b));
    @(posedge clk); #1;
    drive(v.id, 1'b0, v.op + 4'd1, v.a + 4'd3, v.b + 4'd5);
    @(negedge clk);
    check("rsp_latency", 8'(rsp_valid), 8'd1);
    check("alu_a_iso", 8'(alu_a), 8'(v.a));
    check("rsp_x_iso", 8'(rsp_x), 8'(v.x));
    @(posedge clk); #1;
    @(negedge clk);
    check("back_idle_busy", 8'(busy), 8'd0);
    check("back_idle_valid", 8'(rsp_valid), 8'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         n;
    logic       g;
    logic [7:0] r;
    logic [3:0] a0, b0, a1, b1;

    tbl[0] = '{1'b0, 4'b1010, 4'd9, 4'd8, 4'h1, 4'h1};
    tbl[1] = '{1'b1, 4'b1100, 4'd7, 4'd5, 4'h3, 4'h2};
    tbl[2] = '{1'b0, 4'b1100, 4'hF, 4'hF, 4'h1, 4'hE};
    tbl[3] = '{1'b1, 4'b1010, 4'hF, 4'h1, 4'h0, 4'h1};
    tbl[4] = '{1'b0, 4'b0011, 4'h6, 4'h5, 4'h3, 4'h4};
    tbl[5] = '{1'b1, 4'b1111, 4'hA, 4'hC, 4'h6, 4'h8};
    tbl[6] = '{1'b0, 4'b1010, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[7] = '{1'b1, 4'b1100, 4'h0, 4'h9, 4'h0, 4'h0};

    rst = 1'b1; rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_alu_op", 8'(alu_op), 8'd0);
    check("rst_alu_a", 8'(alu_a), 8'd0);
    check("rst_rsp_x", 8'(rsp_x), 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table of single operations.
    for (int i = 0; i < 8; i++) do_op(tbl[i]);

    // Fairness: both continuously valid after a fresh reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd4;
    drive(1'b0, 1'b1, 4'b1010, a0, b0);
    drive(1'b1, 1'b1, 4'b1100, a1, b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge clk);
        n++;
      end
      g = req1_ready;
      check("fair_grant", 8'(g), 8'(i % 2));
      check("fair_one_hot", 8'(req0_ready & req1_ready), 8'd0);
      if (g) r = alu_model(4'b1100, a1, b1);
      else   r = alu_model(4'b1010, a0, b0);
      sb_q.push_back('{g, r[3:0], r[7:4]});
      @(posedge clk); #1;
      if (g) begin
        a1 = a1 + 4'd3; b1 = b1 + 4'd2;
        drive(1'b1, 1'b1, 4'b1100, a1, b1);
      end else begin
        a0 = a0 + 4'd5; b0 = b0 + 4'd7;
        drive(1'b0, 1'b1, 4'b1010, a0, b0);
      end
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    check("fair_drain", 8'(sb_q.size()), 8'd0);

    // Backpressure with req1 waiting.
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 4'b1010, 4'd3, 4'd4);
    @(negedge clk);
    check("bp_req0_ready", 8'(req0_ready), 8'd1);
    sb_q.push_back('{1'b0, 4'd7, 4'd0});
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    drive(1'b1, 1'b1, 4'b1100, 4'd2, 4'd3);
    @(negedge clk);
    check("bp_issue_req1_ready", 8'(req1_ready), 8'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 8'(rsp_valid), 8'd1);
      check("bp_rsp_x", 8'(rsp_x), 8'd7);
      check("bp_rsp_y", 8'(rsp_y), 8'd0);
      check("bp_rsp_id", 8'(rsp_id), 8'd0);
      check("bp_ready0", 8'(req0_ready), 8'd0);
      check("bp_ready1", 8'(req1_ready), 8'd0);
      check("bp_busy", 8'(busy), 8'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_req1_grant", 8'(req1_ready), 8'd1);
    check("bp_req0_idle", 8'(req0_ready), 8'd0);
    sb_q.push_back('{1'b1, 4'd6, 4'd0});
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;

    // Reset during ISSUE discards the operation.
    drive(1'b0, 1'b1, 4'b0101, 4'hA, 4'h3);
    @(negedge clk);
    check("rst_req_accept", 8'(req0_ready), 8'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_issue_busy", 8'(busy), 8'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 8'(busy), 8'd0);
    check("mid_rst_rsp_valid", 8'(rsp_valid), 8'd0);
    check("mid_rst_alu_op", 8'(alu_op), 8'd0);
    check("mid_rst_alu_a", 8'(alu_a), 8'd0);
    check("mid_rst_alu_b", 8'(alu_b), 8'd0);
    check("mid_rst_rsp_x", 8'(rsp_x), 8'd0);
    check("mid_rst_rsp_y", 8'(rsp_y), 8'd0);
    check("mid_rst_rsp_id", 8'(rsp_id), 8'd0);
    check("mid_rst_ready0", 8'(req0_ready), 8'd0);
    check("mid_rst_ready1", 8'(req1_ready), 8'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_rsp", 8'(rsp_valid), 8'd0);
    end

    check("sb_drain", 8'(sb_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4-bit ALU. Each requester presents an opcode and two operands over a valid/ready handshake. The block grants one request at a time, holds the operands on the ALU inputs for a full settle cycle, and registers the ALU result. It then returns the result with the winning requester's ID over a valid/ready response channel. It sits between the requesting datapath blocks and the single combinational ALU instance.

## Interface
- W, 4, operand and result width; must equal the ALU data width
- OPW, 4, opcode width; must equal the ALU opcode width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_op  in  OPW  requester 0 opcode
- req0_a, req0_b  in  W  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as above, for requester 1
- alu_op  out  OPW  opcode to the ALU
- alu_a, alu_b  out  W  operands to the ALU
- alu_x  in  W  ALU low result, combinational from alu_op/alu_a/alu_b
- alu_y  in  W  ALU high result (carry or upper product/shift bits), combinational
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  1  requester that owns the result (0 or 1)
- rsp_x, rsp_y  out  W  registered alu_x and alu_y
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Arbitrate between the requesters.
  - If only one valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - The granted reqK_ready is asserted combinationally (state==IDLE && grant==K). The other ready stays low.
  - On handshake, capture reqK_op/a/b into op_r/a_r/b_r, set id_r=K and last_grant=K, and go to ISSUE.
  - With no valid request, stay in IDLE and keep last_grant.
- alu_op, alu_a and alu_b are driven directly from op_r, a_r and b_r. They change only on an accepted request.
- ISSUE: always lasts exactly one cycle. At its end, capture alu_x into rsp_x and alu_y into rsp_y, then go to RESP.
- RESP:
  - rsp_valid is high, and rsp_id, rsp_x and rsp_y are held stable.
  - On rsp_valid && rsp_ready, go to IDLE.
  - Both reqK_ready are low throughout RESP.
- The opcode is not decoded; all 2^OPW codes are passed through. Result meaning is defined solely by the ALU.
- Requesters must hold op/a/b stable while valid && !ready. The arbiter does not recheck a request after the handshake.
- Round-robin guarantee: while both requesters are continuously valid, grants alternate strictly, so neither starves.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - op_r, a_r, b_r = 0, so alu_op/alu_a/alu_b = 0.
  - rsp_valid=0, rsp_id=0, rsp_x=0, rsp_y=0, busy=0.
- Because last_grant resets to 1, the first grant when both are valid goes to requester 0.
- Latency:
  - Handshake in cycle T, ISSUE in T+1, rsp_valid rises in T+2.
  - With rsp_ready held high, rsp_valid is high for one cycle and IDLE is back in T+3.
  - Maximum throughput is one operation every 3 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely, with outputs frozen and no new grants.
- A new request is never accepted in the same cycle as a response handshake. The state must pass through IDLE first.
- Reset mid-operation: rst in any state returns to IDLE on the next edge. Any in-flight request and result are discarded, with no response issued.
- rst has priority over all handshakes in the same cycle.
- busy equals (state != IDLE), registered via the state.

## Test plan
- Single add:
  - Stimulus: req0 op=4'b1010, a=9, b=8.
  - Required: req0_ready in the same cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_x=4'h1, rsp_y=4'h1 (carry).
- Multiply from requester 1:
  - Stimulus: req1 op=4'b1100, a=7, b=5.
  - Required: rsp_id=1, rsp_x=4'h3, rsp_y=4'h2.
- Fairness:
  - Stimulus: both requesters continuously valid for 6 operations after reset.
  - Required: grant order 0,1,0,1,0,1; every response carries the matching id and the correct result.
- Backpressure:
  - Stimulus: rsp_ready held low for 5 cycles during RESP while req1 is valid.
  - Required: rsp_* stable; req0_ready=req1_ready=0; busy=1 throughout; req1 granted in the first IDLE after release.
- Reset mid-operation:
  - Stimulus: assert rst in the ISSUE cycle of a req0 op=4'b0101, a=4'hA, b=4'h3 request.
  - Required: next cycle state IDLE, rsp_valid=0, all outputs at reset values; no response is ever produced for that request.
- Operand isolation:
  - Stimulus: change req0_a and req0_b while in ISSUE and RESP.
  - Required: alu_a, alu_b and rsp_x unchanged; the result reflects the captured operands only.
